// File: rtl/fir_pkg.sv
// Shared types and helpers for the fir_inverse all-pole IIR.
// FIR_INV_SAT_EN selects saturating instead of wrapping narrowing.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_inv_state_e;

  function automatic int fir_inv_width_a(input int wy, input int wx, input int wb);
    return wy + wx + wb;
  endfunction

  function automatic logic fits(input logic signed [127:0] acc, input int wx);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (wx - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    return (acc <= hi) && (acc >= lo);
  endfunction

  // Result is sign-extended; callers keep only the low wx bits.
  function automatic logic signed [127:0] narrow(input logic signed [127:0] acc, input int wx);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (wx - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
`ifdef FIR_INV_SAT_EN
    if (acc > hi) return hi;
    else if (acc < lo) return lo;
    else return acc;
`else
    if (hi < lo) return '0;
    return (acc <<< (128 - wx)) >>> (128 - wx);
`endif
  endfunction

endpackage

// File: rtl/fir_inv_hist.sv
// History of emitted samples: hist[0] is the newest, read at a runtime index.
module fir_inv_hist #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int IW    = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic [IW-1:0]    idx,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (shift) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++)
      if (idx == IW'(i)) dout = mem[i];
  end

endmodule

// File: rtl/fir_inverse.sv
// All-pole IIR undoing fir_filter, one tap per cycle on a single multiplier.
// Define FIR_INV_SAT_EN for saturating output narrowing (default wraps).
module fir_inverse
  import fir_pkg::*;
#(
  parameter int N       = 4,
  parameter int WIDTH_X = 8,
  parameter int WIDTH_B = 8,
  parameter int WIDTH_Y = WIDTH_X + WIDTH_B + N,
  parameter logic [WIDTH_B-1:0] B [N] = '{default: '0}
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic [WIDTH_Y-1:0] y,
  input  logic               y_valid,
  output logic               y_ready,
  output logic [WIDTH_X-1:0] x,
  output logic               x_valid,
  input  logic               x_ready,
  output logic               ovf
);

  localparam int WIDTH_A = fir_inv_width_a(WIDTH_Y, WIDTH_X, WIDTH_B);
  localparam int KW      = (N > 1) ? $clog2(N) : 1;
  localparam int HD      = (N > 1) ? N - 1 : 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  fir_inv_state_e             state;
  logic [KW-1:0]              k;
  logic signed [WIDTH_A-1:0]  acc;
  logic signed [WIDTH_A-1:0]  acc_nxt;
  logic signed [WIDTH_A-1:0]  prod;
  logic signed [WIDTH_B-1:0]  coef;
  logic [WIDTH_X-1:0]         hist_q;
  logic signed [WIDTH_X-1:0]  hv;
  logic [WIDTH_X-1:0]         x_nxt;
  logic                       ovf_nxt;
  logic                       hist_shift;

  assign y_ready    = rstn && (state == IDLE);
  assign x_valid    = (state == OUT);
  assign hist_shift = (state == OUT) && x_ready && !clr;
  assign hv         = $signed(hist_q);

  fir_inv_hist #(
    .WIDTH (WIDTH_X),
    .DEPTH (HD),
    .IW    (KW)
  ) u_hist (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clr),
    .shift (hist_shift),
    .din   (x),
    .idx   (k - KW'(1)),
    .dout  (hist_q)
  );

  // B[0] is implicitly 1, so only taps 1..N-1 reach the multiplier.
  always_comb begin
    coef = '0;
    for (int i = 1; i < N; i++)
      if (k == KW'(i)) coef = B[i];
  end

  assign prod = WIDTH_A'(coef) * WIDTH_A'(hv);

  always_comb begin
    acc_nxt = acc - prod;
    if (state == IDLE) acc_nxt = WIDTH_A'($signed(y));
  end

  assign x_nxt   = WIDTH_X'(narrow(128'(acc_nxt), WIDTH_X));
  assign ovf_nxt = ovf | ~fits(128'(acc_nxt), WIDTH_X);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      acc   <= '0;
      k     <= '0;
      x     <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      acc   <= '0;
      k     <= '0;
      x     <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (y_valid) begin
            acc <= acc_nxt;
            k   <= KW'(1);
            if (N == 1) begin
              state <= OUT;
              x     <= x_nxt;
              ovf   <= ovf_nxt;
            end else begin
              state <= MAC;
            end
          end
        end
        MAC: begin
          acc <= acc_nxt;
          k   <= k + KW'(1);
          if (k == KW'(N - 1)) begin
            state <= OUT;
            x     <= x_nxt;
            ovf   <= ovf_nxt;
          end
        end
        OUT: begin
          if (x_ready) begin
            state <= IDLE;
            k     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
